inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder.sv | 131 +++++++++++++
 tb/tb_inst_encoder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// RV32E instruction encoder: packs decoded fields into a 32-bit word by format,
// validates immediates and register numbers, and buffers the result in one output register.
`ifndef INST_R
`define TYPE_BUS 2:0
`define INST_R 3'd0
`define INST_I 3'd1
`define INST_S 3'd2
`define INST_B 3'd3
`define INST_U 3'd4
`define INST_J 3'd5
`endif

module inst_encoder (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [`TYPE_BUS] in_type,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [2:0]       err_code,
    output logic [15:0]      enc_count
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    localparam logic [2:0] ERR_OK    = 3'b000;
    localparam logic [2:0] ERR_RANGE = 3'b001;
    localparam logic [2:0] ERR_ALIGN = 3'b010;
    localparam logic [2:0] ERR_REG   = 3'b011;
    localparam logic [2:0] ERR_TYPE  = 3'b100;

    logic [0:0]  state;
    logic [31:0] raw_inst;
    logic [31:0] enc_inst;
    logic [2:0]  enc_code;
    logic        bad_type;
    logic        bad_reg;
    logic        misaligned;
    logic        out_of_range;
    logic        accept;

    assign out_valid = (state == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    always_comb begin
        raw_inst     = '0;
        bad_type     = 1'b0;
        bad_reg      = 1'b0;
        misaligned   = 1'b0;
        out_of_range = 1'b0;
        case (in_type)
            `INST_R: begin
                raw_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                bad_reg  = in_rd[4] | in_rs1[4] | in_rs2[4];
            end
            `INST_I: begin
                raw_inst     = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                bad_reg      = in_rd[4] | in_rs1[4];
                out_of_range = in_imm != {{20{in_imm[11]}}, in_imm[11:0]};
            end
            `INST_S: begin
                raw_inst     = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                bad_reg      = in_rs1[4] | in_rs2[4];
                out_of_range = in_imm != {{20{in_imm[11]}}, in_imm[11:0]};
            end
            `INST_B: begin
                raw_inst     = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:1], in_imm[11], in_opcode};
                bad_reg      = in_rs1[4] | in_rs2[4];
                misaligned   = in_imm[0];
                out_of_range = in_imm != {{19{in_imm[12]}}, in_imm[12:0]};
            end
            `INST_U: begin
                raw_inst   = {in_imm[31:12], in_rd, in_opcode};
                bad_reg    = in_rd[4];
                misaligned = |in_imm[11:0];
            end
            `INST_J: begin
                raw_inst     = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                in_rd, in_opcode};
                bad_reg      = in_rd[4];
                misaligned   = in_imm[0];
                out_of_range = in_imm != {{11{in_imm[20]}}, in_imm[20:0]};
            end
            default: bad_type = 1'b1;
        endcase

        // Highest-priority cause wins when several checks trip together.
        if (bad_type)          enc_code = ERR_TYPE;
        else if (bad_reg)      enc_code = ERR_REG;
        else if (misaligned)   enc_code = ERR_ALIGN;
        else if (out_of_range) enc_code = ERR_RANGE;
        else                   enc_code = ERR_OK;

        enc_inst = (enc_code == ERR_OK) ? raw_inst : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_inst  <= '0;
            out_err   <= 1'b0;
            err_code  <= ERR_OK;
            enc_count <= '0;
        end else begin
            if (out_valid && out_ready && !out_err)
                enc_count <= enc_count + 16'd1;
            if (accept) begin
                state    <= FULL;
                out_inst <= enc_inst;
                out_err  <= (enc_code != ERR_OK);
                err_code <= enc_code;
            end else if (out_ready) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed and random checks of inst_encoder against a transaction-level model
// that encodes from bit positions and signed immediate ranges.
`ifndef INST_R
`define TYPE_BUS 2:0
`define INST_R 3'd0
`define INST_I 3'd1
`define INST_S 3'd2
`define INST_B 3'd3
`define INST_U 3'd4
`define INST_J 3'd5
`endif

module tb_inst_encoder;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [`TYPE_BUS] in_type;
    logic [6:0]       in_opcode;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [2:0]       in_funct3;
    logic [6:0]       in_funct7;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_inst;
    logic             out_err;
    logic [2:0]       err_code;
    logic [15:0]      enc_count;

    int n_assert = 0;
    int n_fail   = 0;

    logic        m_valid;
    logic [31:0] m_inst;
    logic        m_err;
    logic [2:0]  m_code;
    logic [15:0] m_count;

    inst_encoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_err(out_err), .err_code(err_code), .enc_count(enc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference encoding: fields placed by arithmetic shifts, ranges as signed bounds.
    task automatic model_enc(output logic [31:0] inst, output logic [2:0] code);
        int          s;
        int          t;
        logic [31:0] imm;
        logic [31:0] base;
        logic        reg_bad;
        logic        align_bad;
        logic        range_bad;
        imm  = in_imm;
        s    = $signed(imm);
        t    = int'(in_type);
        base = 32'(in_opcode) + (32'(in_rd) << 7) + (32'(in_funct3) << 12)
             + (32'(in_rs1) << 15) + (32'(in_rs2) << 20) + (32'(in_funct7) << 25);
        reg_bad = 0; align_bad = 0; range_bad = 0; inst = 0;
        case (t)
            0: begin
                inst = base;
                reg_bad = (in_rd > 15) || (in_rs1 > 15) || (in_rs2 > 15);
            end
            1: begin
                inst = 32'(in_opcode) + (32'(in_rd) << 7) + (32'(in_funct3) << 12)
                     + (32'(in_rs1) << 15) + ((imm % 4096) << 20);
                reg_bad = (in_rd > 15) || (in_rs1 > 15);
                range_bad = (s < -2048) || (s > 2047);
            end
            2: begin
                inst = 32'(in_opcode) + ((imm % 32) << 7) + (32'(in_funct3) << 12)
                     + (32'(in_rs1) << 15) + (32'(in_rs2) << 20) + (((imm / 32) % 128) << 25);
                reg_bad = (in_rs1 > 15) || (in_rs2 > 15);
                range_bad = (s < -2048) || (s > 2047);
            end
            3: begin
                inst = 32'(in_opcode) + (((imm / 2048) % 2) << 7) + (((imm / 2) % 16) << 8)
                     + (32'(in_funct3) << 12) + (32'(in_rs1) << 15) + (32'(in_rs2) << 20)
                     + (((imm / 32) % 64) << 25) + (((imm / 4096) % 2) << 31);
                reg_bad = (in_rs1 > 15) || (in_rs2 > 15);
                align_bad = (imm % 2) != 0;
                range_bad = (s < -4096) || (s > 4095);
            end
            4: begin
                inst = 32'(in_opcode) + (32'(in_rd) << 7) + ((imm / 4096) << 12);
                reg_bad = in_rd > 15;
                align_bad = (imm % 4096) != 0;
            end
            5: begin
                inst = 32'(in_opcode) + (32'(in_rd) << 7) + (((imm / 4096) % 256) << 12)
                     + (((imm / 2048) % 2) << 20) + (((imm / 2) % 1024) << 21)
                     + (((imm / 1048576) % 2) << 31);
                reg_bad = in_rd > 15;
                align_bad = (imm % 2) != 0;
                range_bad = (s < -1048576) || (s > 1048575);
            end
            default: ;
        endcase
        if (t > 5)          code = 3'd4;
        else if (reg_bad)   code = 3'd3;
        else if (align_bad) code = 3'd2;
        else if (range_bad) code = 3'd1;
        else                code = 3'd0;
        if (code != 0) inst = 0;
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("enc_count", 32'(enc_count), 32'(m_count));
        if (m_valid) begin
            chk("out_inst", out_inst, m_inst);
            chk("out_err", 32'(out_err), 32'(m_err));
            chk("err_code", 32'(err_code), 32'(m_code));
        end
    endtask

    // One clock: drive at negedge, check in_ready, advance model, check at next negedge.
    task automatic step(input logic v, input logic r);
        logic [31:0] ei;
        logic [2:0]  ec;
        logic        rdy;
        in_valid  = v;
        out_ready = r;
        #1;
        rdy = !m_valid || r;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        model_enc(ei, ec);
        if (m_valid && r && !m_err) m_count = m_count + 16'd1;
        if (v && rdy) begin
            m_valid = 1; m_inst = ei; m_code = ec; m_err = (ec != 0);
        end else if (r) begin
            m_valid = 0;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_req(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] imm);
        in_type = t; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    task automatic model_reset();
        m_valid = 0; m_inst = 0; m_err = 0; m_code = 0; m_count = 0;
    endtask

    task automatic rand_req();
        logic [4:0] r[3];
        logic [31:0] imm;
        for (int k = 0; k < 3; k++)
            r[k] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(16, 31))
                                               : 5'($urandom_range(0, 15));
        case ($urandom_range(0, 3))
            0: imm = $urandom;
            1: imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
            2: imm = $urandom & ~32'hFFF;
            default: imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
        endcase
        set_req(3'($urandom_range(0, 7)), 7'($urandom), r[0], r[1], r[2],
                3'($urandom), 7'($urandom), imm);
    endtask

    initial begin
        model_reset();
        in_valid = 0; out_ready = 0; rst_n = 0;
        set_req(`INST_R, 7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_inst", out_inst, 32'd0);
        chk("reset_err_code", 32'(err_code), 32'd0);
        chk("reset_out_err", 32'(out_err), 32'd0);
        chk("reset_enc_count", 32'(enc_count), 32'd0);
        rst_n = 1;
        @(negedge clk);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);

        set_req(`INST_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
        step(1, 1);
        chk("vec_i_addi", out_inst, 32'hFFF00093);
        chk("vec_i_err", 32'(out_err), 32'd0);

        set_req(`INST_B, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC);
        step(1, 1);
        chk("vec_b_beq", out_inst, 32'hFE208EE3);
        in_imm = 32'h00001000;
        step(1, 1);
        chk("vec_b_range_code", 32'(err_code), 32'd1);
        chk("vec_b_range_inst", out_inst, 32'd0);

        set_req(`INST_U, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        step(1, 1);
        chk("vec_u_lui", out_inst, 32'h123452B7);
        in_imm = 32'h12345004;
        step(1, 1);
        chk("vec_u_align", 32'(err_code), 32'd2);

        set_req(`INST_J, 7'b1101111, 5'd16, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        step(1, 1);
        chk("vec_j_badreg", 32'(err_code), 32'd3);
        chk("vec_j_badreg_err", 32'(out_err), 32'd1);

        set_req(3'd6, 7'h33, 5'd31, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        step(1, 1);
        chk("vec_bad_type", 32'(err_code), 32'd4);
        step(0, 1);

        // Backpressure: first accept fills, then three stalled cycles.
        set_req(`INST_R, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0);
        step(1, 0);
        for (int k = 0; k < 3; k++) begin
            in_rd = 5'(k + 6);
            step(1, 0);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            in_rd = 5'(k + 10);
            step(1, 1);
        end
        step(0, 1);

        for (int k = 0; k < 400; k++) begin
            rand_req();
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
        end
        step(0, 1);

        // Mid-cycle reset while FULL discards the pending word.
        set_req(`INST_U, 7'b0110111, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000);
        step(1, 0);
        in_valid = 0;
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("async_reset_valid", 32'(out_valid), 32'd0);
        chk("async_reset_inst", out_inst, 32'd0);
        chk("async_reset_count", 32'(enc_count), 32'd0);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        step(0, 1);
        step(0, 1);

        // Counter wrap through a long stream of good R-type words.
        for (int k = 0; k < 70000 && m_count != 16'hFFFF; k++) begin
            set_req(`INST_R, 7'($urandom), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                    5'($urandom_range(0, 15)), 3'($urandom), 7'($urandom), $urandom);
            step(1, 1);
        end
        chk("count_at_ffff", 32'(enc_count), 32'h0000FFFF);
        step(0, 1);
        chk("count_wrap", 32'(enc_count), 32'd0);
        step(0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
